// File: rtl/uni_reg_pkg.sv
// uni_reg_pkg: mode codes and transmitter states shared by the universal register, its serial feeder and their benches.
package uni_reg_pkg;
  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_SHR  = 2'd1;
  localparam logic [1:0] MODE_SHL  = 2'd2;
  localparam logic [1:0] MODE_LOAD = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} tx_state_t;
endpackage

// File: rtl/uni_reg_serial_tx.sv
// uni_reg_serial_tx: feeds a universal shift register bit by bit on negedge clk; UNIREG_PLOAD_EN adds a one-cycle parallel-load path.
module uni_reg_serial_tx
  import uni_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] datain,
`ifdef UNIREG_PLOAD_EN
  input  logic             fast,
  output logic [WIDTH-1:0] entparalela,
`endif
  output logic [1:0]       modo,
  output logic             serder,
  output logic             serizq,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  tx_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             dir_q;
  always_ff @(negedge clk or negedge clear) begin
    if (!clear) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      cnt    <= '0;
      dir_q  <= 1'b0;
      modo   <= MODE_HOLD;
      serder <= 1'b0;
      serizq <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef UNIREG_PLOAD_EN
      entparalela <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          // shreg holds the bits still to be sent; the first one goes out on this edge
          shreg  <= dir ? datain >> 1 : datain << 1;
          dir_q  <= dir;
          cnt    <= '0;
          busy   <= 1'b1;
          state  <= ST_SHIFT;
          modo   <= dir ? MODE_SHL : MODE_SHR;
          serder <= !dir && datain[WIDTH-1];
          serizq <= dir && datain[0];
`ifdef UNIREG_PLOAD_EN
          // a parallel load is a SHIFT that is already on its last cycle
          if (fast) begin
            cnt         <= LAST;
            modo        <= MODE_LOAD;
            serder      <= 1'b0;
            serizq      <= 1'b0;
            entparalela <= datain;
          end
`endif
        end
        ST_SHIFT: if (cnt == LAST) begin
          state  <= ST_DONE;
          modo   <= MODE_HOLD;
          serder <= 1'b0;
          serizq <= 1'b0;
          done   <= 1'b1;
`ifdef UNIREG_PLOAD_EN
          entparalela <= '0;
`endif
        end else begin
          shreg  <= dir_q ? shreg >> 1 : shreg << 1;
          serder <= !dir_q && shreg[WIDTH-1];
          serizq <= dir_q && shreg[0];
          cnt    <= cnt + 1'b1;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
